// File: rtl/frame_byte_reader_pkg.sv
// Shared widths and state encoding for the frame byte reader.
package frame_byte_reader_pkg;

   localparam int unsigned FRAME_BYTES = 16;
   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned FRAME_W     = FRAME_BYTES * BYTE_W;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

endpackage

// File: rtl/frame_byte_reader.sv
// Serialises a captured multi-byte frame into a byte stream, lowest byte
// first, with a one-hot select and last-byte flag; all outputs registered.
module frame_byte_reader
   import frame_byte_reader_pkg::*;
#(
   parameter int unsigned NUM_BYTES = FRAME_BYTES,
   parameter int unsigned BYTE_W    = frame_byte_reader_pkg::BYTE_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_BYTES*BYTE_W-1:0]   frame_in,
   input  logic                          frame_valid,
   output logic                          frame_ready,
   output logic [BYTE_W-1:0]             byte_out,
   output logic                          byte_valid,
   input  logic                          byte_ready,
   output logic [NUM_BYTES-1:0]          byte_sel,
   output logic                          byte_last
);

   localparam int unsigned IDX_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam int unsigned LAST_I = NUM_BYTES - 1;

   state_t                        state, state_n;
   logic [IDX_W-1:0]              idx, idx_n;
   logic [NUM_BYTES*BYTE_W-1:0]   shadow, shadow_n;
   logic                          frame_ready_n;
   logic                          byte_valid_n;
   logic [BYTE_W-1:0]             byte_out_n;
   logic [NUM_BYTES-1:0]          byte_sel_n;
   logic                          byte_last_n;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         idx         <= '0;
         shadow      <= '0;
         frame_ready <= 1'b0;
         byte_valid  <= 1'b0;
         byte_out    <= '0;
         byte_sel    <= '0;
         byte_last   <= 1'b0;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         shadow      <= shadow_n;
         frame_ready <= frame_ready_n;
         byte_valid  <= byte_valid_n;
         byte_out    <= byte_out_n;
         byte_sel    <= byte_sel_n;
         byte_last   <= byte_last_n;
      end
   end

   // Next state; outputs are computed one cycle ahead so they leave registers
   always_comb begin
      state_n       = state;
      idx_n         = idx;
      shadow_n      = shadow;
      frame_ready_n = frame_ready;
      byte_valid_n  = byte_valid;
      byte_out_n    = byte_out;
      byte_sel_n    = byte_sel;
      byte_last_n   = byte_last;

      case (state)
         ST_IDLE: begin
            frame_ready_n = 1'b1;
            byte_valid_n  = 1'b0;
            byte_out_n    = '0;
            byte_sel_n    = '0;
            byte_last_n   = 1'b0;
            if (frame_valid && frame_ready) begin
               shadow_n      = frame_in;
               idx_n         = '0;
               state_n       = ST_SEND;
               frame_ready_n = 1'b0;
               byte_valid_n  = 1'b1;
               byte_out_n    = frame_in[BYTE_W-1:0];
               byte_sel_n    = NUM_BYTES'(1);
               byte_last_n   = (LAST_I == 0);
            end
         end
         ST_SEND: begin
            frame_ready_n = 1'b0;
            if (byte_valid && byte_ready) begin
               if (byte_last) begin
                  state_n       = ST_IDLE;
                  idx_n         = '0;
                  frame_ready_n = 1'b1;
                  byte_valid_n  = 1'b0;
                  byte_out_n    = '0;
                  byte_sel_n    = '0;
                  byte_last_n   = 1'b0;
               end else begin
                  idx_n       = IDX_W'(idx + 1'b1);
                  byte_out_n  = shadow[idx_n*BYTE_W +: BYTE_W];
                  byte_sel_n  = NUM_BYTES'(1) << idx_n;
                  byte_last_n = (idx_n == IDX_W'(LAST_I));
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_frame_byte_reader.sv
// Scoreboard bench for frame_byte_reader: stimulus queues expected bytes,
// a monitor pops and compares them on every byte handshake.
module tb_frame_byte_reader;

   logic           clk = 1'b0;
   logic           rst;
   logic [127:0]   frame_in;
   logic           frame_valid;
   logic           frame_ready;
   logic [7:0]     byte_out;
   logic           byte_valid;
   logic           byte_ready;
   logic [15:0]    byte_sel;
   logic           byte_last;

   typedef struct packed {
      logic [7:0]  b;
      logic [15:0] sel;
      logic        last;
   } exp_t;

   exp_t exp_q[$];
   int   ft[$];
   int   lt[$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   frame_byte_reader dut (
      .clk         (clk),
      .rst         (rst),
      .frame_in    (frame_in),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .byte_out    (byte_out),
      .byte_valid  (byte_valid),
      .byte_ready  (byte_ready),
      .byte_sel    (byte_sel),
      .byte_last   (byte_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic logic [127:0] make_frame(input logic [7:0] base);
      logic [127:0] f;
      for (int i = 0; i < 16; i++) f[i*8 +: 8] = 8'(base + 8'(i));
      return f;
   endfunction

   task automatic push_frame(input logic [127:0] f);
      exp_t e;
      for (int i = 0; i < 16; i++) begin
         e.b    = f[i*8 +: 8];
         e.sel  = 16'(1) << i;
         e.last = (i == 15);
         exp_q.push_back(e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (frame_ready !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      chk("wait_frame_ready", 32'(frame_ready), 32'd1);
   endtask

   task automatic wait_sel(input logic [15:0] s);
      int n = 0;
      while (!(byte_valid === 1'b1 && byte_sel === s) && n < 100) begin
         step();
         n++;
      end
      chk("wait_byte_sel", 32'(byte_sel), 32'(s));
   endtask

   task automatic send_frame(input logic [127:0] f);
      wait_ready();
      frame_valid = 1'b1;
      frame_in    = f;
      push_frame(f);
      step();
      frame_valid = 1'b0;
   endtask

   task automatic wait_empty();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain_scoreboard", 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: compare every accepted byte against the scoreboard head
   always @(negedge clk) begin
      if (rst === 1'b0 && byte_valid === 1'b1 && byte_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got 0x%0h sel 0x%0h, expected none", byte_out, byte_sel);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("byte_out", 32'(byte_out), 32'(e.b));
            chk("byte_sel", 32'(byte_sel), 32'(e.sel));
            chk("byte_last", 32'(byte_last), 32'(e.last));
         end
         if (byte_sel === 16'h0001) ft.push_back(cyc);
         if (byte_last === 1'b1) lt.push_back(cyc);
      end
      if (byte_valid === 1'b1 && frame_ready === 1'b1) begin
         checks++;
         errors++;
         $display("FAIL ready_while_busy: got frame_ready=1 with byte_valid=1, expected 0");
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [127:0] f_inc;
      logic [127:0] f_busy;
      logic [127:0] f_a;
      logic [127:0] f_b;
      f_inc  = make_frame(8'h00);
      f_busy = make_frame(8'h20);
      f_a    = make_frame(8'h40);
      f_b    = make_frame(8'hC0);

      // Reset held with frame_valid asserted
      rst         = 1'b1;
      frame_valid = 1'b1;
      frame_in    = f_inc;
      byte_ready  = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("rst_frame_ready", 32'(frame_ready), 32'd0);
         chk("rst_byte_valid", 32'(byte_valid), 32'd0);
         chk("rst_byte_out", 32'(byte_out), 32'd0);
         chk("rst_byte_sel", 32'(byte_sel), 32'd0);
         chk("rst_byte_last", 32'(byte_last), 32'd0);
      end
      step();
      rst         = 1'b0;
      frame_valid = 1'b0;
      @(negedge clk);
      chk("pre_release_ready", 32'(frame_ready), 32'd0);
      @(negedge clk);
      chk("release_ready", 32'(frame_ready), 32'd1);
      chk("release_valid", 32'(byte_valid), 32'd0);

      // Full frame, byte i = i
      ft.delete(); lt.delete();
      send_frame(f_inc);
      wait_empty();
      @(negedge clk);
      chk("idle_ready_after_frame", 32'(frame_ready), 32'd1);
      chk("idle_sel_after_frame", 32'(byte_sel), 32'd0);
      chk("full_frame_span", 32'(lt[0] - ft[0]), 32'd15);

      // Backpressure on byte 5
      ft.delete(); lt.delete();
      send_frame(f_inc);
      wait_sel(16'h0020);
      byte_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("stall_byte_out", 32'(byte_out), 32'h05);
         chk("stall_byte_sel", 32'(byte_sel), 32'h0020);
         step();
      end
      byte_ready = 1'b1;
      step();
      chk("after_stall_sel", 32'(byte_sel), 32'h0040);
      wait_empty();
      chk("stall_frame_span", 32'(lt[0] - ft[0]), 32'd18);

      // Frame offered while busy is ignored
      send_frame(f_busy);
      wait_sel(16'h0008);
      frame_valid = 1'b1;
      frame_in    = {16{8'hAA}};
      repeat (2) begin
         @(negedge clk);
         chk("busy_frame_ready", 32'(frame_ready), 32'd0);
         step();
      end
      frame_valid = 1'b0;
      wait_empty();
      repeat (2) @(negedge clk);
      chk("busy_no_extra_frame", 32'(byte_valid), 32'd0);

      // Reset while byte 7 is presented
      send_frame(f_inc);
      wait_sel(16'h0080);
      rst = 1'b1;
      exp_q.delete();
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_byte_valid", 32'(byte_valid), 32'd0);
      chk("midrst_byte_sel", 32'(byte_sel), 32'd0);
      chk("midrst_frame_ready", 32'(frame_ready), 32'd0);
      @(negedge clk);
      chk("midrst_ready_back", 32'(frame_ready), 32'd1);
      ft.delete(); lt.delete();
      send_frame(f_busy);
      wait_empty();
      chk("midrst_restart_frames", 32'(ft.size()), 32'd1);

      // Back-to-back frames with frame_valid held high
      ft.delete(); lt.delete();
      wait_ready();
      frame_valid = 1'b1;
      frame_in    = f_a;
      push_frame(f_a);
      step();
      frame_in = f_b;
      push_frame(f_b);
      begin
         int n = 0;
         while (frame_ready !== 1'b1 && n < 100) begin step(); n++; end
         n = 0;
         while (frame_ready !== 1'b0 && n < 10) begin step(); n++; end
      end
      frame_valid = 1'b0;
      wait_empty();
      chk("b2b_frames_seen", 32'(ft.size()), 32'd2);
      if (ft.size() == 2) chk("b2b_period", 32'(ft[1] - ft[0]), 32'd17);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
